// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: receiver state encoding and
// frame/baud constants also used by the transmitter and FIFOs.
package uart_pkg;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 10416;
  localparam int UART_DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Receive-side byte stream from the deserializer to the rx FIFO,
// plus the per-frame status pulses.
interface uart_rx_deserializer_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_deserializer_sync.sv
// Generic two-flop single-bit synchronizer with a
// parameterised reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 serial-to-parallel receive stage feeding the rx FIFO
// through a valid/ready handshake.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                   pclk,
  input  logic                   Reset,
  input  logic                   rx,
  uart_rx_deserializer_if.master rx_if
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HALF =
    TW'(half_bit(CLKS_PER_BIT));
  localparam logic [TW-1:0] T_BIT =
    TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST =
    BW'(DATA_BITS - 1);

  logic w_rx_s;

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic [TW-1:0]        r_timer;
  logic [TW-1:0]        w_timer_nxt;
  logic [BW-1:0]        r_bitcnt;
  logic [BW-1:0]        w_bitcnt_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;

  logic w_accept;
  logic w_ferr;
  logic w_load;
  logic w_clear;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;

  // Line idles high, so the synchronizer resets to 1
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (pclk),
    .rst (Reset),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  always_ff @(posedge pclk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = '0;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_accept     = 1'b0;
    w_ferr       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt  = START;
          w_bitcnt_nxt = '0;
        end
      end

      START: begin
        if (r_timer == T_HALF) begin
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      DATA: begin
        if (r_timer == T_BIT) begin
          w_shift_nxt =
            DATA_BITS'({w_rx_s, r_shift} >> 1);
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == B_LAST) begin
            w_state_nxt = STOP;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      STOP: begin
        if (r_timer == T_BIT) begin
          if (w_rx_s) begin
            w_accept    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = BREAK;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      BREAK: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A load in the same cycle as a FIFO pop replaces the byte
  assign w_clear = r_valid && rx_if.rx_ready;
  assign w_load  = w_accept && (!r_valid || rx_if.rx_ready);

  always_ff @(posedge pclk) begin
    if (Reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_accept && !w_load;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_clear) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data   = r_data;
  assign rx_if.rx_valid  = r_valid;
  assign rx_if.frame_err = r_ferr;
  assign rx_if.overrun   = r_ovr;
  assign rx_if.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed and randomized frame checks for the UART receive
// deserializer against a frame-level reference model.
module tb_uart_rx_deserializer;

  localparam int C = 16;
  localparam int D = 8;
  localparam int LAT = 3 + C / 2 + (D + 1) * C + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;

  uart_rx_deserializer_if #(.DATA_BITS(D)) u_if ();

  uart_rx_deserializer #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (D)
  ) dut (
    .pclk  (clk),
    .Reset (rst),
    .rx    (rx_line),
    .rx_if (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int n_vcyc, n_ferr, n_ovr, n_brise;
  int t_valid, t_busy;
  logic p_valid, p_busy;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.rx_valid) n_vcyc++;
    if (u_if.rx_valid && !p_valid) t_valid = cyc;
    if (u_if.busy && !p_busy) begin
      t_busy = cyc;
      n_brise++;
    end
    if (u_if.frame_err) n_ferr++;
    if (u_if.overrun) n_ovr++;
    if (u_if.rx_valid && u_if.rx_ready)
      got.push_back(u_if.rx_data);
    p_valid = u_if.rx_valid;
    p_busy  = u_if.busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    n_vcyc  = 0;
    n_ferr  = 0;
    n_ovr   = 0;
    n_brise = 0;
    t_valid = -1;
    t_busy  = -1;
    got.delete();
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return 32'(got[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    rx_line = 1'b0;
    tick(C);
    for (int i = 0; i < D; i++) begin
      rx_line = b[i];
      tick(C);
    end
    rx_line = stop;
    tick(C);
  endtask

  initial begin
    int s;
    int gap;
    int nf_exp;
    logic [7:0] b;
    logic bad;

    u_if.rx_ready = 1'b1;
    p_valid = 1'b0;
    p_busy  = 1'b0;
    clear_obs();
    tick(4);

    chk("rst_data", 32'(u_if.rx_data), 0);
    chk("rst_valid", 32'(u_if.rx_valid), 0);
    chk("rst_ferr", 32'(u_if.frame_err), 0);
    chk("rst_ovr", 32'(u_if.overrun), 0);
    chk("rst_busy", 32'(u_if.busy), 0);
    rst = 1'b0;
    tick(5);

    // Single 0x55 frame and its latency
    clear_obs();
    s = cyc;
    send_frame(8'h55, 1'b1);
    tick(8);
    chk("b55_cnt", 32'(got.size()), 1);
    chk("b55_data", got_at(0), 32'h55);
    chk("b55_lat", 32'(t_valid - s), 32'(LAT));
    chk("b55_vlen", 32'(n_vcyc), 1);
    chk("b55_busy_lat", 32'(t_busy - s), 3);
    chk("b55_ferr", 32'(n_ferr), 0);
    chk("b55_ovr", 32'(n_ovr), 0);
    chk("b55_idle", 32'(u_if.busy), 0);

    // Back-to-back frames
    clear_obs();
    send_frame(8'h55, 1'b1);
    send_frame(8'hCC, 1'b1);
    tick(8);
    chk("b2b_cnt", 32'(got.size()), 2);
    chk("b2b_d0", got_at(0), 32'h55);
    chk("b2b_d1", got_at(1), 32'hCC);
    chk("b2b_ferr", 32'(n_ferr), 0);

    // Short glitch: false start
    clear_obs();
    s = cyc;
    rx_line = 1'b0;
    tick(5);
    rx_line = 1'b1;
    tick(6);
    chk("gl_busy_hi", 32'(u_if.busy), 1);
    tick(1);
    chk("gl_busy_lo", 32'(u_if.busy), 0);
    chk("gl_busy_lat", 32'(t_busy - s), 3);
    tick(20);
    chk("gl_valid", 32'(n_vcyc), 0);
    chk("gl_ferr", 32'(n_ferr), 0);
    chk("gl_busy_end", 32'(u_if.busy), 0);

    // Bad stop bit then line held low
    clear_obs();
    send_frame(8'hA3, 1'b0);
    tick(40);
    chk("fe_busy", 32'(u_if.busy), 1);
    chk("fe_cnt", 32'(n_ferr), 1);
    chk("fe_valid", 32'(n_vcyc), 0);
    rx_line = 1'b1;
    tick(6);
    chk("fe_idle", 32'(u_if.busy), 0);
    tick(30);
    chk("fe_cnt2", 32'(n_ferr), 1);
    chk("fe_brise", 32'(n_brise), 1);
    chk("fe_valid2", 32'(n_vcyc), 0);

    // Overrun while the FIFO is full
    clear_obs();
    u_if.rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    tick(5);
    chk("ov_valid", 32'(u_if.rx_valid), 1);
    chk("ov_data", 32'(u_if.rx_data), 32'h12);
    chk("ov_pulse", 32'(n_ovr), 1);
    chk("ov_nopop", 32'(got.size()), 0);
    u_if.rx_ready = 1'b1;
    tick(1);
    chk("ov_clear", 32'(u_if.rx_valid), 0);
    chk("ov_pop", got_at(0), 32'h12);
    u_if.rx_ready = 1'b0;

    // Pop and load in the same cycle
    send_frame(8'h77, 1'b1);
    tick(3);
    clear_obs();
    s = cyc;
    fork
      send_frame(8'h56, 1'b1);
      begin
        tick(LAT - 1);
        u_if.rx_ready = 1'b1;
        tick(1);
        u_if.rx_ready = 1'b0;
      end
    join
    chk("ld_valid", 32'(u_if.rx_valid), 1);
    chk("ld_data", 32'(u_if.rx_data), 32'h56);
    chk("ld_ovr", 32'(n_ovr), 0);
    chk("ld_pop", got_at(0), 32'h77);
    chk("ld_popcnt", 32'(got.size()), 1);

    // Reset in the middle of data bit 4
    clear_obs();
    fork
      send_frame(8'hF0, 1'b1);
      begin
        tick(3 + C / 2 + 5 * C);
        chk("mr_busy_pre", 32'(u_if.busy), 1);
        chk("mr_valid_pre", 32'(u_if.rx_valid), 1);
        rst = 1'b1;
        tick(1);
        chk("mr_data", 32'(u_if.rx_data), 0);
        chk("mr_valid", 32'(u_if.rx_valid), 0);
        chk("mr_ferr", 32'(u_if.frame_err), 0);
        chk("mr_ovr", 32'(u_if.overrun), 0);
        chk("mr_busy", 32'(u_if.busy), 0);
        rst = 1'b0;
      end
    join
    tick(10);
    chk("mr_nobyte", 32'(got.size()), 0);
    chk("mr_noerr", 32'(n_ferr + n_ovr), 0);
    u_if.rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    tick(8);
    chk("mr_5a_cnt", 32'(got.size()), 1);
    chk("mr_5a", got_at(0), 32'h5A);

    // Randomized frames against the frame-level model
    clear_obs();
    exp_q.delete();
    nf_exp = 0;
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad);
      rx_line = 1'b1;
      if (bad) begin
        nf_exp++;
        gap = $urandom_range(C, 3 * C);
      end else begin
        exp_q.push_back(b);
        gap = $urandom_range(0, 3 * C);
      end
      if (gap > 0) tick(gap);
    end
    tick(2 * C);
    chk("rnd_cnt", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_d%0d", i), got_at(i),
          32'(exp_q[i]));
    chk("rnd_ferr", 32'(n_ferr), 32'(nf_exp));
    chk("rnd_ovr", 32'(n_ovr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial-to-parallel receive stage of the UART peripheral. It samples the asynchronous `rx` pin, validates start and stop bits, assembles 8N1 frames (LSB first) and presents each byte to the UART receive FIFO through a valid/ready handshake. It sits directly upstream of the rx FIFO that APB reads drain, and runs on `pclk`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10416: `pclk` cycles per bit (100 MHz / 9600 baud). Must be at least 4.
- `DATA_BITS`, default 8: data bits per frame.

Ports:
- `pclk`  in  1  system clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  DATA_BITS  received byte; held stable while `rx_valid` is high.
- `rx_valid`  out  1  byte available to the FIFO.
- `rx_ready`  in  1  FIFO can accept a byte (not full).
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped because `rx_valid` is still high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input `rx` passes through a 2-flop synchronizer, giving `rx_s`. The synchronizer flops reset to 1.
- The state machine has five states:
  - IDLE: waits for `rx_s` to be 0. It then clears the bit counter and enters START.
  - START: counts `CLKS_PER_BIT/2` cycles (integer division), then samples `rx_s`.
    - If the sample is 1, the start was false: return to IDLE with no pulse.
    - If the sample is 0, enter DATA.
  - DATA: samples `rx_s` every `CLKS_PER_BIT` cycles into the shift register, LSB first.
    - After `DATA_BITS` samples, enter STOP.
  - STOP: samples once after `CLKS_PER_BIT` cycles.
    - If the sample is 1, the byte is accepted: go to IDLE.
    - If the sample is 0, pulse `frame_err`, discard the byte and enter BREAK.
  - BREAK: waits until `rx_s` is 1, then goes to IDLE. This stops a held-low line from retriggering.
- Accepted-byte handling:
  - If `rx_valid` is 0, load `rx_data` and set `rx_valid`.
  - If `rx_valid` is 1, pulse `overrun` and keep the old `rx_data`.
  - The new byte is dropped in that case.
- Handshake:
  - `rx_valid` clears on any cycle where `rx_valid` and `rx_ready` are both high.
  - If a clear and a new byte load happen in the same cycle, the load wins: `rx_valid` stays 1, `rx_data` takes the new byte, and there is no overrun.
- Counter widths: the bit timer is `$clog2(CLKS_PER_BIT)` bits and the bit counter is `$clog2(DATA_BITS+1)` bits. Neither wraps; both reload on every state entry.
- Reset mid-frame returns the block to IDLE immediately. The partial byte is lost and no pulses are issued.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state=IDLE.
- Start detection: `busy` rises 3 cycles after the falling edge of `rx` (2 synchronizer cycles + 1 state-register cycle).
- Sample points relative to the START entry cycle:
  - start bit: at `CLKS_PER_BIT/2`
  - data bit k: at `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`
  - stop bit: at `CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT`
- `rx_valid`, `frame_err` and `overrun` assert in the cycle after the stop-bit sample (registered outputs). `busy` falls in that same cycle.
- Back-to-back frames: the block is in IDLE after the stop-bit sample, which is half a bit before the stop bit ends. A start edge immediately following the stop bit is therefore detected.
- `rx_ready` is sampled combinationally. There is no limit on how long `rx_valid` may be held.

## Structure
- Shared package `uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, STOP, BREAK)
  - constants `UART_DEFAULT_CLKS_PER_BIT`=10416 and `UART_DATA_BITS`=8, also used by the transmitter and the FIFOs.
- One sub-module, `sync_2ff`: a generic single-bit synchronizer with a parameterised reset value. It is reused for GPIO inputs.
- The FSM, bit timer, shift register and output holding register are all in the top module.

## Test plan
Directed tests use `CLKS_PER_BIT`=16 and `rx_ready`=1 unless stated.

- Bit sequence 0,1,0,1,0,1,0,1,0,1 (start, data, stop) -> `rx_data`=0x55 with a one-cycle `rx_valid`, 3+8+144+1 cycles after the start edge; no error pulses.
- Back-to-back frames 0x55 then 0xCC (data bits 0,0,1,1,0,0,1,1), second start edge directly after the first stop bit -> two valid bytes 0x55 and 0xCC, no gap errors.
- A 5-cycle low glitch on idle `rx` -> returns to IDLE after the start-bit sample; `rx_valid`, `frame_err` and `busy` all low afterwards.
- Frame 0xA3 with stop bit 0, then `rx` held low for 40 cycles -> a single `frame_err` pulse, no `rx_valid`, `busy` stays high until `rx` returns high, no retrigger.
- `rx_ready`=0, send 0x12 then 0x34 -> `rx_valid` stays high with `rx_data`=0x12 and `overrun` pulses once. Raise `rx_ready` -> `rx_valid` clears the next cycle. Send 0x56 with `rx_ready` pulsed in the exact load cycle -> `rx_data`=0x56, `rx_valid` stays 1, no overrun.
- `Reset` asserted during data bit 4 of a frame -> next cycle all outputs are at reset values. A following clean 0x5A frame is received correctly.
